// File: rtl/never8_pkg.sv
// Shared types and constants for the never8 instruction fetch unit.
// Holds the fetch FSM encoding, default bus widths and the length-flag position.
package never8_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned LEN_BIT    = 7;

    typedef enum logic [1:0] {
        ISSUE     = 2'd0,
        LATCH_OP  = 2'd1,
        LATCH_ARG = 2'd2,
        HOLD      = 2'd3
    } fetch_state_t;

    // Instruction length in bytes, from the opcode length flag.
    function automatic int unsigned instr_len(input logic len_flag);
        return len_flag ? 32'd2 : 32'd1;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: program memory read port, redirect input and decoder handshake.
// master = fetch unit, slave = memory/decoder side.
interface instr_fetch_if
    import never8_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] opcode;
    logic [DATA_W-1:0] operand;
    logic [ADDR_W-1:0] pc_out;

    modport master (
        output mem_address,
        output instr_valid,
        output opcode,
        output operand,
        output pc_out,
        input  mem_data,
        input  jump_en,
        input  jump_addr,
        input  instr_ready
    );

    modport slave (
        input  mem_address,
        input  instr_valid,
        input  opcode,
        input  operand,
        input  pc_out,
        output mem_data,
        output jump_en,
        output jump_addr,
        output instr_ready
    );

endinterface

// File: rtl/instr_fetch.sv
// Variable-length (1/2 byte) instruction fetch from a sync-read program memory,
// presenting whole instructions to the decoder with a valid/ready handshake.
module instr_fetch
    import never8_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter int unsigned       DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic           clk,
    input logic           reset_n,
    instr_fetch_if.master bus
);

    fetch_state_t      state_q, state_nx;
    logic [ADDR_W-1:0] pc_q, pc_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic [ADDR_W-1:0] pc_out_q, pc_out_nx;
    logic [DATA_W-1:0] opcode_q, opcode_nx;
    logic [DATA_W-1:0] operand_q, operand_nx;
    logic              valid_q, valid_nx;

    // State and output registers; reset overrides jump and handshake.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ISSUE;
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
            pc_out_q  <= RESET_PC;
            opcode_q  <= '0;
            operand_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_nx;
            pc_q      <= pc_nx;
            addr_q    <= addr_nx;
            pc_out_q  <= pc_out_nx;
            opcode_q  <= opcode_nx;
            operand_q <= operand_nx;
            valid_q   <= valid_nx;
        end
    end

    // Next state; mem_address is registered, so it is loaded for the state being entered.
    always_comb begin
        state_nx   = state_q;
        pc_nx      = pc_q;
        addr_nx    = addr_q;
        pc_out_nx  = pc_out_q;
        opcode_nx  = opcode_q;
        operand_nx = operand_q;
        valid_nx   = 1'b0;

        case (state_q)
            ISSUE: begin
                state_nx = LATCH_OP;
                addr_nx  = pc_q + ADDR_W'(1);
            end
            LATCH_OP: begin
                opcode_nx = bus.mem_data;
                pc_out_nx = pc_q;
                if (bus.mem_data[LEN_BIT]) begin
                    state_nx = LATCH_ARG;
                end else begin
                    operand_nx = '0;
                    state_nx   = HOLD;
                    valid_nx   = 1'b1;
                end
            end
            LATCH_ARG: begin
                operand_nx = bus.mem_data;
                state_nx   = HOLD;
                valid_nx   = 1'b1;
            end
            HOLD: begin
                if (bus.instr_ready) begin
                    pc_nx    = pc_q + ADDR_W'(instr_len(opcode_q[LEN_BIT]));
                    addr_nx  = pc_nx;
                    state_nx = ISSUE;
                end else begin
                    valid_nx = 1'b1;
                end
            end
            default: begin
                state_nx = ISSUE;
                addr_nx  = pc_q;
            end
        endcase

        // A redirect discards any partial or held instruction; its target wins for pc.
        if (bus.jump_en) begin
            pc_nx    = bus.jump_addr;
            addr_nx  = bus.jump_addr;
            state_nx = ISSUE;
            valid_nx = 1'b0;
        end
    end

    assign bus.mem_address = addr_q;
    assign bus.instr_valid = valid_q;
    assign bus.opcode      = opcode_q;
    assign bus.operand     = operand_q;
    assign bus.pc_out      = pc_out_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch with a 1-cycle sync-read program memory model.
module tb_instr_fetch;

    typedef struct {
        logic [7:0] opcode;
        logic [7:0] operand;
        logic [7:0] pc;
    } exp_t;

    typedef struct {
        logic [7:0] pc;
        logic [7:0] op;
        logic [7:0] arg;
        logic [7:0] exp_opcode;
        logic [7:0] exp_operand;
        logic [7:0] exp_next;
        int         lat;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] mem [256];
    exp_t       exp_q[$];
    vec_t       vecs[8];
    int         checks = 0;
    int         errors = 0;

    instr_fetch_if bus ();

    instr_fetch #(
        .ADDR_W  (8),
        .DATA_W  (8),
        .RESET_PC(8'h00)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    // Program memory: address seen at an edge, data valid after it.
    always @(posedge clk) bus.mem_data <= mem[bus.mem_address];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Push the expected instruction, wait for instr_valid, then pop and compare.
    task automatic expect_instr(input logic [7:0] op, input logic [7:0] opnd,
                                input logic [7:0] pc, input int lat, input string name);
        exp_t e;
        int   n;
        exp_q.push_back('{op, opnd, pc});
        n = 0;
        while (bus.instr_valid !== 1'b1 && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.instr_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: instr_valid still low after %0d cycles", name, n);
            void'(exp_q.pop_front());
            return;
        end
        e = exp_q.pop_front();
        chk({name, "_opcode"},  32'(bus.opcode),  32'(e.opcode));
        chk({name, "_operand"}, 32'(bus.operand), 32'(e.operand));
        chk({name, "_pc_out"},  32'(bus.pc_out),  32'(e.pc));
        chk({name, "_latency"}, 32'(n),           32'(lat));
    endtask

    task automatic handshake(input logic [7:0] next_pc, input string name);
        bus.instr_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_ready = 1'b0;
        chk({name, "_valid_drop"}, 32'(bus.instr_valid), 32'h0);
        chk({name, "_next_addr"},  32'(bus.mem_address), 32'(next_pc));
    endtask

    task automatic do_jump(input logic [7:0] target, input string name);
        bus.jump_addr = target;
        bus.jump_en   = 1'b1;
        @(posedge clk);
        #1;
        bus.jump_en = 1'b0;
        chk({name, "_valid_drop"}, 32'(bus.instr_valid), 32'h0);
        chk({name, "_addr"},       32'(bus.mem_address), 32'(target));
    endtask

    initial begin
        //            pc     op     arg    exp_op exp_arg next   lat
        vecs[0] = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 2};
        vecs[1] = '{8'h01, 8'h02, 8'h00, 8'h02, 8'h00, 8'h02, 2};
        vecs[2] = '{8'h02, 8'h80, 8'h11, 8'h80, 8'h11, 8'h04, 3};
        vecs[3] = '{8'h04, 8'h8A, 8'h3C, 8'h8A, 8'h3C, 8'h06, 3};
        vecs[4] = '{8'h06, 8'h7F, 8'h00, 8'h7F, 8'h00, 8'h07, 2};
        vecs[5] = '{8'h07, 8'hFF, 8'h22, 8'hFF, 8'h22, 8'h09, 3};
        vecs[6] = '{8'h09, 8'hC0, 8'h00, 8'hC0, 8'h00, 8'h0B, 3};
        vecs[7] = '{8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0C, 2};

        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        for (int i = 0; i < 8; i++) begin
            mem[vecs[i].pc] = vecs[i].op;
            if (vecs[i].op[7]) mem[vecs[i].pc + 8'h01] = vecs[i].arg;
        end
        mem[8'h20] = 8'h85;
        mem[8'h21] = 8'h66;
        mem[8'h30] = 8'h90;
        mem[8'h31] = 8'h77;
        mem[8'h40] = 8'h03;
        mem[8'h50] = 8'h04;
        mem[8'hFF] = 8'h8A;

        reset_n         = 1'b0;
        bus.instr_ready = 1'b0;
        bus.jump_en     = 1'b0;
        bus.jump_addr   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_address", 32'(bus.mem_address), 32'h0);
        chk("rst_valid",       32'(bus.instr_valid), 32'h0);
        chk("rst_opcode",      32'(bus.opcode),      32'h0);
        chk("rst_operand",     32'(bus.operand),     32'h0);
        chk("rst_pc_out",      32'(bus.pc_out),      32'h0);
        reset_n = 1'b1;

        // Straight-line program of mixed one- and two-byte instructions.
        for (int i = 0; i < 8; i++) begin
            expect_instr(vecs[i].exp_opcode, vecs[i].exp_operand, vecs[i].pc,
                         vecs[i].lat, $sformatf("vec%0d", i));
            handshake(vecs[i].exp_next, $sformatf("vec%0d", i));
        end

        // Decoder stall in HOLD: everything frozen, then exactly one handshake.
        do_jump(8'h20, "jmp20");
        expect_instr(8'h85, 8'h66, 8'h20, 3, "stall");
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d_valid", c),   32'(bus.instr_valid), 32'h1);
            chk($sformatf("stall%0d_opcode", c),  32'(bus.opcode),      32'h85);
            chk($sformatf("stall%0d_operand", c), 32'(bus.operand),     32'h66);
            chk($sformatf("stall%0d_pc_out", c),  32'(bus.pc_out),      32'h20);
            chk($sformatf("stall%0d_addr", c),    32'(bus.mem_address), 32'h21);
        end
        handshake(8'h22, "stall");
        expect_instr(8'h00, 8'h00, 8'h22, 2, "after_stall");

        // Two-byte opcode at FF takes its operand from 00; ready held high while invalid.
        mem[8'h00] = 8'h55;
        do_jump(8'hFF, "jmpff");
        bus.instr_ready = 1'b1;
        expect_instr(8'h8A, 8'h55, 8'hFF, 3, "wrap");
        handshake(8'h01, "wrap");
        expect_instr(8'h02, 8'h00, 8'h01, 2, "after_wrap");

        // Redirect during LATCH_ARG drops the partial instruction.
        do_jump(8'h30, "jmp30");
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        do_jump(8'h40, "jmp40_in_arg");
        expect_instr(8'h03, 8'h00, 8'h40, 2, "redirect");

        // Jump and handshake on the same edge: target wins for pc.
        bus.instr_ready = 1'b1;
        do_jump(8'h50, "jmp_hs");
        bus.instr_ready = 1'b0;
        expect_instr(8'h04, 8'h00, 8'h50, 2, "jmp_hs");

        // One-edge reset while holding, with ready high: fetch restarts at RESET_PC.
        bus.instr_ready = 1'b1;
        reset_n         = 1'b0;
        @(posedge clk);
        #1;
        reset_n         = 1'b1;
        bus.instr_ready = 1'b0;
        chk("rst2_valid",   32'(bus.instr_valid), 32'h0);
        chk("rst2_pc_out",  32'(bus.pc_out),      32'h0);
        chk("rst2_addr",    32'(bus.mem_address), 32'h0);
        chk("rst2_opcode",  32'(bus.opcode),      32'h0);
        chk("rst2_operand", 32'(bus.operand),     32'h0);
        expect_instr(8'h55, 8'h00, 8'h00, 2, "restart");
        handshake(8'h01, "restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_W, default 8, program address width.
REQ-002 Parameter DATA_W, default 8, program byte width.
REQ-003 Parameter RESET_PC, default 8'h00, first fetch address after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset, sampled on rising clk edge.
REQ-006 mem_address  output  ADDR_W  address to program_mem; registered output.
REQ-007 mem_data  input  DATA_W  program_mem data_out; byte for an address presented at edge k is valid after edge k and sampled at edge k+1.
REQ-008 jump_en  input  1  redirect request, one-cycle pulse.
REQ-009 jump_addr  input  ADDR_W  redirect target, qualified by jump_en.
REQ-010 instr_valid  output  1  opcode/operand/pc_out hold a complete instruction.
REQ-011 instr_ready  input  1  decoder accepts the instruction.
REQ-012 opcode  output  DATA_W  first instruction byte.
REQ-013 operand  output  DATA_W  second byte; 8'h00 for one-byte instructions.
REQ-014 pc_out  output  ADDR_W  address of the presented opcode.

Function
REQ-015 Instruction length SHALL be 2 bytes when opcode[7]=1, otherwise 1 byte.
REQ-016 FSM SHALL have states ISSUE, LATCH_OP, LATCH_ARG, HOLD.
REQ-017 ISSUE: mem_address=pc; next state LATCH_OP.
REQ-018 LATCH_OP: mem_address=pc+1; at edge opcode<=mem_data; next LATCH_ARG if mem_data[7]=1, else HOLD with operand<=8'h00.
REQ-019 LATCH_ARG: at edge operand<=mem_data; next HOLD.
REQ-020 HOLD: instr_valid=1; opcode, operand and pc_out stable until handshake.
REQ-021 Handshake completes on an edge with instr_valid=1 and instr_ready=1; pc<=pc+length; next ISSUE; instr_valid=0 the following cycle.
REQ-022 Latency from entering ISSUE to instr_valid=1: 2 cycles for one-byte, 3 cycles for two-byte instructions.
REQ-023 instr_ready while instr_valid=0 SHALL be ignored.
REQ-024 pc arithmetic SHALL be modulo 2^ADDR_W: operand of an opcode at 8'hFF is read from 8'h00; pc 8'hFF + 1 = 8'h00, 8'hFF + 2 = 8'h01.
REQ-025 jump_en=1 in any state SHALL set pc<=jump_addr, discard any partial or held instruction, enter ISSUE, and drive instr_valid=0 next cycle.
REQ-026 jump_en and completed handshake on the same edge: instruction counts as consumed; jump target wins for pc.
REQ-027 No write path to program memory; block only reads.

Reset
REQ-028 reset_n=0 at an edge SHALL force state ISSUE, pc=RESET_PC, mem_address=RESET_PC, instr_valid=0, opcode=0, operand=0, pc_out=RESET_PC.
REQ-029 Reset SHALL take priority over jump_en and handshake, and SHALL abort a fetch in any state.
REQ-030 First edge with reset_n=1 SHALL be treated as ISSUE for RESET_PC.

Structure
REQ-031 Shared package never8_pkg SHALL hold the FSM state enum, ADDR_W/DATA_W defaults and the LEN_BIT constant (7).
REQ-032 Single module; no sub-module; bench SHALL instantiate program_mem or a sync-read model with identical 1-cycle latency.

Verification
REQ-033 Reset release, M[00]=01, instr_ready=1 -> instr_valid rises 2 cycles after ISSUE with opcode=01, operand=00, pc_out=00; next pc_out=01.
REQ-034 M[04]=8A, M[05]=3C -> opcode=8A, operand=3C, pc_out=04 after 3 cycles; next fetch at 06.
REQ-035 instr_ready=0 for 5 cycles in HOLD -> outputs stable, no mem_address advance; ready=1 -> single handshake.
REQ-036 Opcode 8A at FF, M[00]=55 -> operand=55, next pc_out=01.
REQ-037 jump_en=1, jump_addr=40 during LATCH_ARG -> partial instr discarded, instr_valid=0, next presented pc_out=40.
REQ-038 reset_n=0 for one edge while in HOLD -> instr_valid=0, pc_out=RESET_PC next cycle; fetch restarts at RESET_PC.
